// File: rtl/tick_sched_if.sv
// Bundle of the tick_sched configuration, event handshake and status
// signals. The host side (tick source, configuration writer, event
// consumer) uses the master modport; the scheduler uses the slave modport.
interface tick_sched_if #(
  parameter int NCH = 4,
  parameter int W   = 16
);
  localparam int CW = $clog2(NCH);

  logic           tick;
  logic           cfg_we;
  logic [CW-1:0]  cfg_ch;
  logic           cfg_en;
  logic           cfg_oneshot;
  logic [W-1:0]   cfg_period;
  logic           ev_valid;
  logic [CW-1:0]  ev_ch;
  logic           ev_ready;
  logic [NCH-1:0] busy;
  logic [NCH-1:0] ovr;

  modport master (
    output tick, cfg_we, cfg_ch, cfg_en, cfg_oneshot, cfg_period, ev_ready,
    input  ev_valid, ev_ch, busy, ovr
  );

  modport slave (
    input  tick, cfg_we, cfg_ch, cfg_en, cfg_oneshot, cfg_period, ev_ready,
    output ev_valid, ev_ch, busy, ovr
  );
endinterface

// File: rtl/tick_sched.sv
// Multi-channel tick-driven timer scheduler. Each channel counts base ticks
// down from its period and raises a pending event on expiry; pending events
// are offered one at a time through a round-robin arbiter whose choice is
// locked while the consumer stalls. A repeat expiry on a still-pending,
// unaccepted channel sets that channel's sticky overrun flag.
module tick_sched #(
  parameter int NCH = 4,
  parameter int W   = 16
) (
  input  logic        clk,
  input  logic        rst,
  tick_sched_if.slave bus
);
  localparam int CW = $clog2(NCH);

  logic [W-1:0]   period [NCH];
  logic [W-1:0]   cnt    [NCH];
  logic [NCH-1:0] oneshot;
  logic [NCH-1:0] busy_r;
  logic [NCH-1:0] pend;
  logic [NCH-1:0] ovr_r;
  logic [CW-1:0]  rr;
  logic [CW-1:0]  lock_ch;
  logic           lock_vld;

  logic           any_pend;
  logic           accept;
  logic [CW-1:0]  sel;
  logic           found;
  int             idx;
  logic [CW-1:0]  rr_next;
  logic [NCH-1:0] hit;
  logic [NCH-1:0] fire;
  logic [NCH-1:0] acc;

  // A programmed period of zero behaves as a period of one.
  function automatic logic [W-1:0] clamp_period(input logic [W-1:0] p);
    return (p == '0) ? W'(1) : p;
  endfunction

  assign any_pend     = |pend;
  assign accept       = any_pend && bus.ev_ready;
  assign bus.ev_valid = any_pend;
  assign bus.ev_ch    = lock_vld ? lock_ch : sel;
  assign bus.busy     = busy_r;
  assign bus.ovr      = ovr_r;
  assign rr_next      = (bus.ev_ch == CW'(NCH - 1)) ? '0 : bus.ev_ch + CW'(1);

  // Round-robin search: first pending channel at or after rr, wrapping.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NCH; k++) begin
      idx = int'(rr) + k;
      if (idx >= NCH) idx = idx - NCH;
      if (!found && pend[CW'(idx)]) begin
        sel   = CW'(idx);
        found = 1'b1;
      end
    end
  end

  // Per-channel strobes: config hit, expiry (config wins) and acceptance.
  always_comb begin
    hit  = '0;
    fire = '0;
    acc  = '0;
    for (int i = 0; i < NCH; i++) begin
      hit[i]  = bus.cfg_we && (bus.cfg_ch == CW'(i));
      fire[i] = bus.tick && busy_r[i] && !hit[i] && (cnt[i] <= W'(1));
      acc[i]  = accept && (bus.ev_ch == CW'(i));
    end
  end

  // Channel counters, pending/overrun flags and arbiter lock/pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        cnt[i]    <= '0;
        period[i] <= '0;
      end
      oneshot  <= '0;
      busy_r   <= '0;
      pend     <= '0;
      ovr_r    <= '0;
      rr       <= '0;
      lock_vld <= 1'b0;
      lock_ch  <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (hit[i]) begin
          ovr_r[i] <= 1'b0;
          if (bus.cfg_en) begin
            period[i]  <= clamp_period(bus.cfg_period);
            cnt[i]     <= clamp_period(bus.cfg_period);
            oneshot[i] <= bus.cfg_oneshot;
            busy_r[i]  <= 1'b1;
          end else begin
            busy_r[i] <= 1'b0;
          end
        end else if (fire[i]) begin
          if (pend[i] && !acc[i]) ovr_r[i] <= 1'b1;
          if (oneshot[i]) busy_r[i] <= 1'b0;
          else            cnt[i]    <= period[i];
        end else if (bus.tick && busy_r[i]) begin
          cnt[i] <= cnt[i] - W'(1);
        end
        pend[i] <= fire[i] | (pend[i] & ~acc[i]);
      end
      if (accept) begin
        lock_vld <= 1'b0;
        rr       <= rr_next;
      end else if (any_pend) begin
        lock_vld <= 1'b1;
        lock_ch  <= bus.ev_ch;
      end
    end
  end
endmodule

// File: tb/tb_tick_sched.sv
// Testbench for tick_sched: directed scenarios plus a randomized run, all
// compared against a behavioural model of the timer/arbiter rules.
module tb_tick_sched;
  localparam int NCH = 4;
  localparam int W   = 16;
  localparam int CW  = 2;
  localparam int SW  = 1 + CW + 2 * NCH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tick_sched_if #(.NCH(NCH), .W(W)) bus ();
  tick_sched #(.NCH(NCH), .W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: ticks remaining until expiry per channel.
  int m_per  [NCH];
  int m_rem  [NCH];
  bit m_one  [NCH];
  bit m_busy [NCH];
  bit m_pend [NCH];
  bit m_ovr  [NCH];
  int m_rr;
  bit m_lock;
  int m_lock_ch;

  function automatic bit m_valid();
    for (int i = 0; i < NCH; i++) if (m_pend[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_pick();
    if (m_lock) return m_lock_ch;
    for (int k = 0; k < NCH; k++) if (m_pend[(m_rr + k) % NCH]) return (m_rr + k) % NCH;
    return 0;
  endfunction

  function automatic logic [SW-1:0] m_snap();
    logic [NCH-1:0] b;
    logic [NCH-1:0] o;
    for (int i = 0; i < NCH; i++) begin
      b[i] = m_busy[i];
      o[i] = m_ovr[i];
    end
    return {m_valid(), CW'(m_pick()), b, o};
  endfunction

  function automatic logic [SW-1:0] d_snap();
    return {bus.ev_valid, bus.ev_ch, bus.busy, bus.ovr};
  endfunction

  task automatic model_step();
    bit v;
    int ch;
    bit ac;
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        m_per[i] = 0; m_rem[i] = 0; m_one[i] = 0;
        m_busy[i] = 0; m_pend[i] = 0; m_ovr[i] = 0;
      end
      m_rr = 0; m_lock = 0; m_lock_ch = 0;
      return;
    end
    v  = m_valid();
    ch = m_pick();
    ac = v && bus.ev_ready;
    for (int i = 0; i < NCH; i++) begin
      bit acc_i;
      bit expired;
      acc_i   = ac && (ch == i);
      expired = 1'b0;
      if (bus.cfg_we && int'(bus.cfg_ch) == i) begin
        m_ovr[i] = 1'b0;
        if (bus.cfg_en) begin
          m_per[i]  = (bus.cfg_period == 0) ? 1 : int'(bus.cfg_period);
          m_rem[i]  = m_per[i];
          m_one[i]  = bus.cfg_oneshot;
          m_busy[i] = 1'b1;
        end else begin
          m_busy[i] = 1'b0;
        end
      end else if (bus.tick && m_busy[i]) begin
        if (m_rem[i] > 1) begin
          m_rem[i] = m_rem[i] - 1;
        end else begin
          expired = 1'b1;
          if (m_pend[i] && !acc_i) m_ovr[i] = 1'b1;
          if (m_one[i]) m_busy[i] = 1'b0;
          else          m_rem[i]  = m_per[i];
        end
      end
      m_pend[i] = expired || (m_pend[i] && !acc_i);
    end
    if (ac) begin
      m_lock = 1'b0;
      m_rr   = (ch + 1) % NCH;
    end else if (v) begin
      m_lock    = 1'b1;
      m_lock_ch = ch;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    bus.tick        = 1'b0;
    bus.cfg_we      = 1'b0;
    bus.cfg_ch      = '0;
    bus.cfg_en      = 1'b0;
    bus.cfg_oneshot = 1'b0;
    bus.cfg_period  = '0;
  endtask

  task automatic set_cfg(input int ch, input bit en, input bit one, input int p);
    bus.cfg_we      = 1'b1;
    bus.cfg_ch      = CW'(ch);
    bus.cfg_en      = en;
    bus.cfg_oneshot = one;
    bus.cfg_period  = W'(p);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    bus.ev_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    bus.ev_ready = 1'b1;
    bus.tick     = 1'b1;
    step();
    step();
    n_checks++;
    if (d_snap() !== '0) begin
      n_errors++;
      $display("FAIL reset_state: got %h expected %h", d_snap(), {SW{1'b0}});
    end
    n_checks++;
    if (d_snap() !== m_snap()) begin
      n_errors++;
      $display("FAIL reset_model: got %h expected %h", d_snap(), m_snap());
    end
    rst = 1'b0;
    idle();
  endtask

  task automatic test_periodic();
    int nev;
    do_reset();
    bus.ev_ready = 1'b1;
    set_cfg(0, 1'b1, 1'b0, 3);
    bus.tick = 1'b1;
    step();
    bus.cfg_we = 1'b0;
    nev = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      n_checks++;
      if (d_snap() !== m_snap()) begin
        n_errors++;
        $display("FAIL periodic_model k=%0d: got %h expected %h", k, d_snap(), m_snap());
      end
      n_checks++;
      if (bus.ev_valid !== (k % 3 == 0) || (bus.ev_valid && bus.ev_ch !== 2'd0)) begin
        n_errors++;
        $display("FAIL periodic_pulse k=%0d: got valid=%b ch=%0d expected valid=%b ch=0",
                 k, bus.ev_valid, bus.ev_ch, (k % 3 == 0));
      end
      if (bus.ev_valid === 1'b1) nev++;
    end
    n_checks++;
    if (nev != 4 || bus.ovr[0] !== 1'b0) begin
      n_errors++;
      $display("FAIL periodic_count: got events=%0d ovr0=%b expected events=4 ovr0=0", nev, bus.ovr[0]);
    end
  endtask

  task automatic test_oneshot();
    do_reset();
    bus.ev_ready = 1'b1;
    set_cfg(1, 1'b1, 1'b1, 2);
    step();
    bus.cfg_we = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      bus.tick = (k % 4 == 0);
      step();
      n_checks++;
      if (d_snap() !== m_snap()) begin
        n_errors++;
        $display("FAIL oneshot_model k=%0d: got %h expected %h", k, d_snap(), m_snap());
      end
      n_checks++;
      if (bus.busy[1] !== (k < 8) || bus.ev_valid !== (k == 8) ||
          (bus.ev_valid && bus.ev_ch !== 2'd1)) begin
        n_errors++;
        $display("FAIL oneshot_seq k=%0d: got busy1=%b valid=%b ch=%0d expected busy1=%b valid=%b ch=1",
                 k, bus.busy[1], bus.ev_valid, bus.ev_ch, (k < 8), (k == 8));
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    bus.ev_ready = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      set_cfg(c, 1'b1, 1'b0, 1);
      step();
    end
    bus.cfg_we = 1'b0;
    bus.tick   = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      n_checks++;
      if (d_snap() !== m_snap() || bus.ev_valid !== 1'b1 || bus.ev_ch !== 2'd0) begin
        n_errors++;
        $display("FAIL stall_hold k=%0d: got %h expected %h with ch=0", k, d_snap(), m_snap());
      end
    end
    n_checks++;
    if (bus.ovr !== 4'b1111) begin
      n_errors++;
      $display("FAIL stall_ovr: got %b expected 1111", bus.ovr);
    end
    bus.tick     = 1'b0;
    bus.ev_ready = 1'b1;
    for (int g = 0; g < NCH; g++) begin
      n_checks++;
      if (bus.ev_valid !== 1'b1 || int'(bus.ev_ch) != g) begin
        n_errors++;
        $display("FAIL stall_grant g=%0d: got valid=%b ch=%0d expected valid=1 ch=%0d",
                 g, bus.ev_valid, bus.ev_ch, g);
      end
      step();
    end
    n_checks++;
    if (bus.ev_valid !== 1'b0 || bus.ovr !== 4'b1111 || d_snap() !== m_snap()) begin
      n_errors++;
      $display("FAIL stall_drain: got %h expected %h (valid=0 ovr=1111)", d_snap(), m_snap());
    end
  endtask

  task automatic test_p0_stop();
    do_reset();
    bus.ev_ready = 1'b1;
    set_cfg(2, 1'b1, 1'b0, 0);
    bus.tick = 1'b1;
    step();
    bus.cfg_we = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      n_checks++;
      if (bus.ev_valid !== 1'b1 || bus.ev_ch !== 2'd2 || bus.ovr[2] !== 1'b0 ||
          d_snap() !== m_snap()) begin
        n_errors++;
        $display("FAIL p0_every_tick k=%0d: got %h expected %h", k, d_snap(), m_snap());
      end
    end
    set_cfg(2, 1'b0, 1'b0, 0);
    step();
    bus.cfg_we = 1'b0;
    n_checks++;
    if (bus.ev_valid !== 1'b0 || bus.busy[2] !== 1'b0 || d_snap() !== m_snap()) begin
      n_errors++;
      $display("FAIL stop_with_tick: got valid=%b busy2=%b expected valid=0 busy2=0",
               bus.ev_valid, bus.busy[2]);
    end
    step();
    n_checks++;
    if (bus.ev_valid !== 1'b0 || d_snap() !== m_snap()) begin
      n_errors++;
      $display("FAIL stopped_quiet: got %h expected %h", d_snap(), m_snap());
    end
  endtask

  task automatic test_accept_expiry();
    do_reset();
    bus.ev_ready = 1'b0;
    set_cfg(3, 1'b1, 1'b0, 1);
    step();
    bus.cfg_we = 1'b0;
    bus.tick   = 1'b1;
    step();
    n_checks++;
    if (bus.ev_valid !== 1'b1 || bus.ev_ch !== 2'd3) begin
      n_errors++;
      $display("FAIL acc_exp_first: got valid=%b ch=%0d expected valid=1 ch=3", bus.ev_valid, bus.ev_ch);
    end
    bus.ev_ready = 1'b1;
    step();
    n_checks++;
    if (bus.ev_valid !== 1'b1 || bus.ev_ch !== 2'd3 || bus.ovr[3] !== 1'b0 ||
        d_snap() !== m_snap()) begin
      n_errors++;
      $display("FAIL acc_exp_same: got valid=%b ch=%0d ovr3=%b expected valid=1 ch=3 ovr3=0",
               bus.ev_valid, bus.ev_ch, bus.ovr[3]);
    end
    bus.tick = 1'b0;
    step();
    n_checks++;
    if (bus.ev_valid !== 1'b0 || d_snap() !== m_snap()) begin
      n_errors++;
      $display("FAIL acc_exp_drain: got valid=%b expected 0", bus.ev_valid);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.ev_ready = 1'b0;
    set_cfg(0, 1'b1, 1'b0, 9);
    step();
    set_cfg(1, 1'b1, 1'b0, 1);
    step();
    bus.cfg_we = 1'b0;
    bus.tick   = 1'b1;
    for (int k = 0; k < 4; k++) step();
    n_checks++;
    if (bus.ev_valid !== 1'b1 || bus.ovr[1] !== 1'b1 || d_snap() !== m_snap()) begin
      n_errors++;
      $display("FAIL rstmid_pre: got %h expected %h", d_snap(), m_snap());
    end
    rst          = 1'b1;
    bus.ev_ready = 1'b1;
    set_cfg(2, 1'b1, 1'b0, 1);
    step();
    rst        = 1'b0;
    bus.cfg_we = 1'b0;
    n_checks++;
    if (d_snap() !== '0) begin
      n_errors++;
      $display("FAIL rstmid_clear: got %h expected %h", d_snap(), {SW{1'b0}});
    end
    for (int k = 0; k < 10; k++) begin
      step();
      n_checks++;
      if (bus.ev_valid !== 1'b0 || bus.busy !== 4'b0000 || d_snap() !== m_snap()) begin
        n_errors++;
        $display("FAIL rstmid_quiet k=%0d: got valid=%b busy=%b expected valid=0 busy=0000",
                 k, bus.ev_valid, bus.busy);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      rst             = ($urandom_range(0, 199) == 0);
      bus.tick        = 1'($urandom_range(0, 1));
      bus.cfg_we      = ($urandom_range(0, 7) == 0);
      bus.cfg_ch      = CW'($urandom_range(0, NCH - 1));
      bus.cfg_en      = ($urandom_range(0, 3) != 0);
      bus.cfg_oneshot = 1'($urandom_range(0, 1));
      bus.cfg_period  = W'($urandom_range(0, 4));
      bus.ev_ready    = ($urandom_range(0, 2) == 0);
      step();
      n_checks++;
      if (d_snap() !== m_snap()) begin
        n_errors++;
        $display("FAIL random n=%0d: got %h expected %h", n, d_snap(), m_snap());
      end
    end
    rst = 1'b0;
    idle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    bus.ev_ready = 1'b0;
    test_reset();
    test_periodic();
    test_oneshot();
    test_stall();
    test_p0_stop();
    test_accept_expiry();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/tick_sched.md
TICK_SCHED -- requirements
Module: tick_sched

Interface
REQ-001 Parameter NCH, default 4: number of timer channels, range 2..8.
REQ-002 Parameter W, default 16: width of period and counter registers.
REQ-003 clk  input  1: single clock, all state updates on rising edge.
REQ-004 rst  input  1: reset, synchronous and active-high.
REQ-005 tick  input  1: base clock-enable pulse, one cycle wide, from a clock-enable generator.
REQ-006 cfg_we  input  1: configuration write strobe, one cycle.
REQ-007 cfg_ch  input  $clog2(NCH): channel addressed by cfg_we.
REQ-008 cfg_en  input  1: 1 = start/restart channel, 0 = stop channel.
REQ-009 cfg_oneshot  input  1: 1 = one-shot, 0 = periodic.
REQ-010 cfg_period  input  W: period in tick units; 0 treated as 1.
REQ-011 ev_valid  output  1: at least one channel has a pending event.
REQ-012 ev_ch  output  $clog2(NCH): channel of the offered event.
REQ-013 ev_ready  input  1: consumer accepts the offered event.
REQ-014 busy  output  NCH: per-channel enabled flag.
REQ-015 ovr  output  NCH: per-channel sticky overrun flag.

Function
REQ-016 Each channel SHALL hold period, mode, enable, a W-bit down-counter cnt, a pending bit and an ovr bit.
REQ-017 cfg_we with cfg_en=1 SHALL load period, mode and cnt=max(cfg_period,1), set busy, and clear ovr for cfg_ch; pending is left unchanged.
REQ-018 cfg_we with cfg_en=0 SHALL clear busy and ovr for cfg_ch; counter is frozen; pending is left unchanged.
REQ-019 When tick=1 and busy=1 and cnt>1, cnt SHALL decrement by 1.
REQ-020 When tick=1 and busy=1 and cnt==1 (expiry): pending SHALL set; periodic reloads cnt=period; one-shot clears busy.
REQ-021 Period P periodic SHALL expire on every P-th tick after start; P=1 expires on every tick.
REQ-022 Expiry while pending already set and not being accepted that cycle SHALL set ovr (sticky); pending stays 1, no second event queued.
REQ-023 cfg_we and tick to the same channel in the same cycle: cfg_we SHALL take precedence; the tick is ignored for that channel only.
REQ-024 No channel decrements when tick=0, regardless of cfg activity on other channels.
REQ-025 ev_valid SHALL be the OR of all pending bits, combinational from registers; event visible the cycle after the expiring tick edge.
REQ-026 Arbiter SHALL be round-robin: ev_ch is the first pending channel at or after pointer rr, wrapping NCH-1 -> 0.
REQ-027 While ev_valid=1 and ev_ready=0, ev_ch SHALL be held stable (lock register), even if a higher-priority channel becomes pending.
REQ-028 On ev_valid && ev_ready, pending[ev_ch] SHALL clear, rr SHALL become ev_ch+1 modulo NCH, and lock SHALL release.
REQ-029 Acceptance and expiry of the same channel in one cycle: pending SHALL remain 1, ovr SHALL NOT set.
REQ-030 ev_ready with ev_valid=0 SHALL have no effect.

Reset
REQ-031 rst=1 at a clock edge SHALL clear all cnt, period, mode, busy, pending, ovr, lock and rr=0; ev_valid=0, ev_ch=0 thereafter.
REQ-032 rst SHALL override tick, cfg_we and ev_ready in the same cycle; reset mid-countdown or mid-handshake discards all state.

Verification
REQ-033 Ch0 periodic P=3, tick every cycle, ev_ready=1 -> ev_valid pulses with ev_ch=0 every 3rd cycle, ovr[0]=0.
REQ-034 Ch1 one-shot P=2, tick every 4 cycles -> single event on ch1 after 2nd tick, busy[1] falls same edge, no further events.
REQ-035 Ch0..3 periodic P=1, ev_ready=0 for 3 ticks then 1 -> ev_ch held at 0 while stalled, ovr=4'b1111, then grants 0,1,2,3 in order.
REQ-036 Ch2 P=0 periodic -> treated as P=1, event every tick; cfg_en=0 on ch2 concurrent with tick -> no expiry that cycle, busy[2]=0.
REQ-037 Ch3 P=1 pending, ev_ready=1 in same cycle as next expiry -> pending[3] stays 1, ovr[3]=0, second event offered next cycle.
REQ-038 rst asserted while ch0 cnt=5 and ev_valid=1 stalled -> next cycle ev_valid=0, busy=0, ovr=0, rr=0; no event after rst release without new cfg.
